// File: rtl/seq_alu_if.sv
// Operation/result handshake bundle between the issue stage and seq_alu.
interface seq_alu_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       sel;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] f;
  logic             ovf;
  logic             zero;
  logic             ill;

  modport master (
    output in_valid, a, b, sel, out_ready,
    input  in_ready, out_valid, f, ovf, zero, ill
  );

  modport slave (
    input  in_valid, a, b, sel, out_ready,
    output in_ready, out_valid, f, ovf, zero, ill
  );
endinterface

// File: rtl/seq_alu.sv
// Handshaked multi-cycle ALU: one-cycle logic/add/compare, bit-serial
// shifts and shift-add multiply. Result held until the consumer takes it.
module seq_alu #(
  parameter int unsigned WIDTH  = 32,
  parameter bit          MUL_EN = 1'b1
) (
  input  logic      clk,
  input  logic      rst,
  seq_alu_if.slave  bus
);
  localparam int unsigned SHW = $clog2(WIDTH);
  localparam int unsigned CW  = SHW + 1;
  localparam int unsigned MSB = WIDTH - 1;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_XOR  = 4'h4;
  localparam logic [3:0] OP_NOT  = 4'h5;
  localparam logic [3:0] OP_SLT  = 4'h6;
  localparam logic [3:0] OP_SLTU = 4'h7;
  localparam logic [3:0] OP_SLL  = 4'h8;
  localparam logic [3:0] OP_SRL  = 4'h9;
  localparam logic [3:0] OP_SRA  = 4'hA;
  localparam logic [3:0] OP_MUL  = 4'hB;
  localparam logic [3:0] OP_EQ   = 4'hC;
  localparam logic [3:0] OP_NE   = 4'hD;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state, state_next;
  logic [3:0]       op, op_next;
  logic [WIDTH-1:0] opa, opa_next;
  logic [WIDTH-1:0] opb, opb_next;
  logic [WIDTH-1:0] hi, hi_next;
  logic [CW-1:0]    cnt, cnt_next;
  logic [WIDTH-1:0] f, f_next;
  logic             ovf, ovf_next;
  logic             zero, zero_next;
  logic             ill, ill_next;
  logic             in_ready, out_valid;

  // Scratch values for the single-cycle result and one iterative step.
  logic [WIDTH-1:0] res;
  logic             res_ovf;
  logic             res_ill;
  logic             fast;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] step;
  logic [WIDTH:0]   mul_sum;

  // Next-state, operand capture, iteration and result logic.
  always_comb begin
    state_next = state;
    op_next    = op;
    opa_next   = opa;
    opb_next   = opb;
    hi_next    = hi;
    cnt_next   = cnt;
    f_next     = f;
    ovf_next   = ovf;
    zero_next  = zero;
    ill_next   = ill;
    res        = '0;
    res_ovf    = 1'b0;
    res_ill    = 1'b0;
    fast       = 1'b1;
    shamt      = bus.b[SHW-1:0];
    step       = opa;
    mul_sum    = {1'b0, hi} + (opb[0] ? {1'b0, opa} : {(WIDTH+1){1'b0}});

    // Decode the presented op; only used when it is accepted.
    case (bus.sel)
      OP_ADD: begin
        res     = bus.a + bus.b;
        res_ovf = (bus.a[MSB] == bus.b[MSB]) && (res[MSB] != bus.a[MSB]);
      end
      OP_SUB: begin
        res     = bus.a - bus.b;
        res_ovf = (bus.a[MSB] != bus.b[MSB]) && (res[MSB] != bus.a[MSB]);
      end
      OP_AND:  res = bus.a & bus.b;
      OP_OR:   res = bus.a | bus.b;
      OP_XOR:  res = bus.a ^ bus.b;
      OP_NOT:  res = ~bus.b;
      OP_SLT:  res = WIDTH'($signed(bus.a) < $signed(bus.b));
      OP_SLTU: res = WIDTH'(bus.a < bus.b);
      OP_SLL, OP_SRL, OP_SRA: begin
        res  = bus.a;
        fast = (shamt == '0);
      end
      OP_MUL: begin
        if (MUL_EN) fast = 1'b0;
        else        res_ill = 1'b1;
      end
      OP_EQ:   res = WIDTH'(bus.a == bus.b);
      OP_NE:   res = WIDTH'(bus.a != bus.b);
      default: res_ill = 1'b1;
    endcase

    // One bit of shift per cycle for the serial shifters.
    case (op)
      OP_SLL:  step = {opa[MSB-1:0], 1'b0};
      OP_SRL:  step = {1'b0, opa[MSB:1]};
      OP_SRA:  step = {opa[MSB], opa[MSB:1]};
      default: step = opa;
    endcase

    case (state)
      IDLE: begin
        if (bus.in_valid) begin
          op_next  = bus.sel;
          opa_next = bus.a;
          opb_next = bus.b;
          hi_next  = '0;
          if (fast) begin
            state_next = DONE;
            f_next     = res;
            ovf_next   = res_ovf;
            ill_next   = res_ill;
            zero_next  = (res == '0);
          end else begin
            state_next = BUSY;
            cnt_next   = (bus.sel == OP_MUL) ? CW'(WIDTH) : CW'(shamt);
          end
        end
      end
      BUSY: begin
        cnt_next = cnt - CW'(1);
        if (op == OP_MUL) begin
          hi_next  = mul_sum[WIDTH:1];
          opb_next = {mul_sum[0], opb[MSB:1]};
        end else begin
          opa_next = step;
        end
        if (cnt == CW'(1)) begin
          state_next = DONE;
          ill_next   = 1'b0;
          if (op == OP_MUL) begin
            f_next    = {mul_sum[0], opb[MSB:1]};
            ovf_next  = |mul_sum[WIDTH:1];
            zero_next = ({mul_sum[0], opb[MSB:1]} == '0);
          end else begin
            f_next    = step;
            ovf_next  = 1'b0;
            zero_next = (step == '0);
          end
        end
      end
      DONE: begin
        if (bus.out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State, datapath and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      op        <= '0;
      opa       <= '0;
      opb       <= '0;
      hi        <= '0;
      cnt       <= '0;
      f         <= '0;
      ovf       <= 1'b0;
      zero      <= 1'b0;
      ill       <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      state     <= state_next;
      op        <= op_next;
      opa       <= opa_next;
      opb       <= opb_next;
      hi        <= hi_next;
      cnt       <= cnt_next;
      f         <= f_next;
      ovf       <= ovf_next;
      zero      <= zero_next;
      ill       <= ill_next;
      in_ready  <= (state_next == IDLE);
      out_valid <= (state_next == DONE);
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.f         = f;
  assign bus.ovf       = ovf;
  assign bus.zero      = zero;
  assign bus.ill       = ill;
endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
Parametrised, handshaked, multi-cycle successor to the single-cycle 32-bit datapath ALU. It accepts one operation per transaction on a valid/ready input port. Logic, add and compare ops finish in one cycle. Variable shifts iterate one bit per cycle, and the optional multiply runs shift-add over WIDTH cycles. It sits between the register-read stage and writeback in the multi-cycle CPU and stalls the issue stage via in_ready.

Parameters:
WIDTH, 32, operand/result width in bits (power of two, >=8)
MUL_EN, 1, 1 = MUL opcode implemented; 0 = MUL treated as illegal opcode
SHW, $clog2(WIDTH), derived (localparam), width of shift-amount field

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
in_valid  input  1  operation presented
in_ready  output  1  block can accept an operation
a  input  WIDTH  operand A
b  input  WIDTH  operand B / shift amount in b[SHW-1:0]
sel  input  4  opcode
out_valid  output  1  result held on f/ovf/zero/ill
out_ready  input  1  consumer takes result
f  output  WIDTH  result
ovf  output  1  overflow flag
zero  output  1  f == 0
ill  output  1  illegal opcode flag

Behaviour:
- Opcodes:
  - 0000 ADD: a+b
  - 0001 SUB: a-b
  - 0010 AND
  - 0011 OR
  - 0100 XOR
  - 0101 NOT: ~b
  - 0110 SLT: signed a<b gives 1, else 0
  - 0111 SLTU: unsigned
  - 1000 SLL: a<<b[SHW-1:0]
  - 1001 SRL: logical right
  - 1010 SRA: arithmetic right
  - 1011 MUL: low WIDTH bits of unsigned a*b
  - 1100 EQ: f=1 if a==b
  - 1101 NE: f=1 if a!=b
  - 1110, 1111, and MUL when MUL_EN=0: illegal, f=0, ill=1
- Operands and sel are captured into internal registers on accept (in_valid && in_ready). Inputs are don't-care afterwards.
- FSM IDLE -> BUSY -> DONE -> IDLE:
  - IDLE: in_ready=1, out_valid=0. On accept, go to DONE for single-cycle ops, shifts with amount 0, and illegal ops. Otherwise go to BUSY.
  - BUSY: in_ready=0. Shifts move one bit per cycle and decrement the counter. MUL does one shift-add step per cycle for WIDTH cycles. When the counter reaches 0, go to DONE.
  - DONE: out_valid=1, in_ready=0. f/ovf/zero/ill stay stable until out_ready=1. In that cycle go to IDLE.
- Latency (accept on edge k): single-cycle ops give out_valid=1 after edge k+1. Shift by n gives out_valid after edge k+1+n. MUL gives out_valid after edge k+1+WIDTH.
- No overlap: a new op is not accepted in the same cycle the result is consumed. Minimum issue interval is 2 cycles.
- ovf rules:
  - ADD: a[MSB]==b[MSB] and f[MSB]!=a[MSB]
  - SUB: a[MSB]!=b[MSB] and f[MSB]!=a[MSB]
  - MUL: 1 if the full 2*WIDTH product has any nonzero upper half bit
  - All other ops: 0
- zero is computed from the final f for every op, illegal included (illegal gives zero=1).
- Shift amount uses b[SHW-1:0] only; upper bits of b are ignored. SRA replicates a[MSB] on every step.
- Reset: state=IDLE, in_ready=1 (in reset cycle in_ready may read 1 but no accept occurs), out_valid=0, f=0, ovf=0, zero=0, ill=0, counter=0. Reset in BUSY or DONE aborts the operation; the result is discarded and never presented.
- in_valid in BUSY/DONE is ignored. There is no accept and no state change.
- out_ready while out_valid=0 is ignored.

Test Plan:
- WIDTH=32. ADD a=0x7FFFFFFF, b=1 -> f=0x80000000, ovf=1, zero=0, out_valid after 1 cycle. SUB a=5, b=5 -> f=0, zero=1, ovf=0.
- SLT a=0xFFFFFFFF, b=1 -> f=1. SLTU with the same operands -> f=0. SRA a=0x80000000, b=0x24 (shamt 4) -> f=0xF8000000, out_valid exactly 5 cycles after accept, in_ready=0 throughout.
- SLL a=0x1, b=0 -> f=0x1 after 1 cycle. SLL a=0x1, b=31 -> f=0x80000000 after 32 cycles.
- MUL a=0x10000, b=0x10000 -> f=0, ovf=1, zero=1, latency 33. With MUL_EN=0 the same op -> ill=1, f=0, latency 1.
- Backpressure: hold out_ready=0 for 10 cycles after ADD 3+4 -> f=7 stable, out_valid=1, in_valid pulses ignored. Then out_ready=1 for 1 cycle -> IDLE, in_ready=1 next cycle.
- Assert rst mid-MUL at cycle 10 -> next cycle out_valid=0, in_ready=1, all outputs 0. The aborted result never appears, and a following ADD 1+1 returns f=2.
